// File: rtl/sudoku_pkg.sv
// Shared definitions for the sudoku unit hardware.
//   CELL_W      : digit / candidate-mask width (bits 9:1)
//   UNIT_CELLS  : cells per unit (row, column or box)
//   ADDR_VALUE  : cell word address of the solved value
//   ADDR_MASK   : cell word address of the candidate mask
//   ue_state_e  : unit eliminator sequencing states
package sudoku_pkg;

  localparam int unsigned CELL_W     = 9;
  localparam int unsigned UNIT_CELLS = 9;

  localparam logic ADDR_VALUE = 1'b0;
  localparam logic ADDR_MASK  = 1'b1;

  // Last cell index of a unit, in the 4-bit index width used on the bus.
  localparam logic [3:0] LAST_CELL = 4'(UNIT_CELLS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } ue_state_e;

endpackage : sudoku_pkg

// File: rtl/sudoku_onehot_check.sv
// Combinational classifier for a 9-bit digit word.
//   value_i   : digit word, bits 9:1
//   is_zero_o : no bit set (unsolved cell)
//   is_onehot_o : exactly one bit set (solved cell)
// A word that is neither zero nor one-hot is malformed.
module sudoku_onehot_check
  import sudoku_pkg::*;
(
  input  logic [CELL_W:1] value_i,
  output logic            is_zero_o,
  output logic            is_onehot_o
);

  logic [CELL_W:1] value_m1;

  // Clearing the lowest set bit leaves zero only for one-hot or zero words.
  always_comb begin
    value_m1    = value_i - 1'b1;
    is_zero_o   = (value_i == '0);
    is_onehot_o = !is_zero_o && ((value_i & value_m1) == '0);
  end

endmodule : sudoku_onehot_check

// File: rtl/sudoku_unit_eliminator.sv
// Bus initiator eliminating solved digits from the candidate masks of one
// sudoku unit of 9 cells.
//   clk, reset  : clock, synchronous active-high reset
//   start       : request one elimination pass (sampled in IDLE only)
//   busy, done  : pass in progress / one-cycle completion pulse
//   cell_sel    : selected cell 0..8
//   cell_addr   : 0 = value word, 1 = candidate-mask word
//   cell_we     : write strobe to the selected cell
//   cell_wdata  : write data (bits 9:1)
//   cell_rdata  : combinational read data of the selected cell word
//   used_mask, conflict, malformed, changed : status of the last pass,
//                 updated when DONE is entered
module sudoku_unit_eliminator
  import sudoku_pkg::*;
#(
  parameter int SKIP_WRITE_ON_ERROR = 1,
  parameter int CELL_W              = 9
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [3:0]      cell_sel,
  output logic            cell_addr,
  output logic            cell_we,
  output logic [CELL_W:1] cell_wdata,
  input  logic [CELL_W:1] cell_rdata,
  output logic [CELL_W:1] used_mask,
  output logic            conflict,
  output logic            malformed,
  output logic            changed
);

  ue_state_e state_q, state_d;

  logic [3:0]      idx_q, idx_d;
  logic [CELL_W:1] used_q, used_d;
  logic            conflict_q, conflict_d;
  logic            malformed_q, malformed_d;
  logic            changed_q, changed_d;

  logic [CELL_W:1] st_used_q, st_used_d;
  logic            st_conflict_q, st_conflict_d;
  logic            st_malformed_q, st_malformed_d;
  logic            st_changed_q, st_changed_d;

  logic rd_zero;
  logic rd_onehot;
  logic skip_write;

  sudoku_onehot_check u_onehot (
    .value_i     (cell_rdata),
    .is_zero_o   (rd_zero),
    .is_onehot_o (rd_onehot)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Accumulators and index.  The skip decision at cell 8 looks at the _d
  // error flags so an error found in that same cycle is honoured.
  always_comb begin
    idx_d       = idx_q;
    used_d      = used_q;
    conflict_d  = conflict_q;
    malformed_d = malformed_q;
    changed_d   = changed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d       = '0;
          used_d      = '0;
          conflict_d  = 1'b0;
          malformed_d = 1'b0;
          changed_d   = 1'b0;
        end
      end
      ST_READ: begin
        if (!rd_zero && !rd_onehot) malformed_d = 1'b1;
        if (rd_onehot) begin
          if ((cell_rdata & used_q) != '0) conflict_d = 1'b1;
          used_d = used_q | cell_rdata;
        end
        idx_d = (idx_q == LAST_CELL) ? '0 : idx_q + 4'd1;
      end
      ST_WRITE: begin
        if ((cell_rdata & used_q) != '0) changed_d = 1'b1;
        idx_d = (idx_q == LAST_CELL) ? '0 : idx_q + 4'd1;
      end
      ST_DONE: begin
      end
      default: begin
      end
    endcase
  end

  assign skip_write = (SKIP_WRITE_ON_ERROR != 0) && (conflict_d || malformed_d);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (start) state_d = ST_READ;
      ST_READ:  if (idx_q == LAST_CELL) state_d = skip_write ? ST_DONE : ST_WRITE;
      ST_WRITE: if (idx_q == LAST_CELL) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Status capture on entry to DONE, from the accumulators' next values so
  // the last cell of the pass is included.
  always_comb begin
    st_used_d      = st_used_q;
    st_conflict_d  = st_conflict_q;
    st_malformed_d = st_malformed_q;
    st_changed_d   = st_changed_q;
    if (state_d == ST_DONE && state_q != ST_DONE) begin
      st_used_d      = used_d;
      st_conflict_d  = conflict_d;
      st_malformed_d = malformed_d;
      st_changed_d   = changed_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q          <= '0;
      used_q         <= '0;
      conflict_q     <= 1'b0;
      malformed_q    <= 1'b0;
      changed_q      <= 1'b0;
      st_used_q      <= '0;
      st_conflict_q  <= 1'b0;
      st_malformed_q <= 1'b0;
      st_changed_q   <= 1'b0;
    end else begin
      idx_q          <= idx_d;
      used_q         <= used_d;
      conflict_q     <= conflict_d;
      malformed_q    <= malformed_d;
      changed_q      <= changed_d;
      st_used_q      <= st_used_d;
      st_conflict_q  <= st_conflict_d;
      st_malformed_q <= st_malformed_d;
      st_changed_q   <= st_changed_d;
    end
  end

  // Output logic.  Bus outputs are forced idle while reset is asserted so no
  // write can land in the reset cycle even if the state register was in WRITE.
  always_comb begin
    busy       = (state_q != ST_IDLE);
    done       = (state_q == ST_DONE);
    cell_sel   = '0;
    cell_addr  = ADDR_VALUE;
    cell_we    = 1'b0;
    cell_wdata = '0;
    if (!reset) begin
      unique case (state_q)
        ST_READ: begin
          cell_sel  = idx_q;
          cell_addr = ADDR_VALUE;
        end
        ST_WRITE: begin
          cell_sel   = idx_q;
          cell_addr  = ADDR_MASK;
          cell_we    = 1'b1;
          cell_wdata = ~used_q;
        end
        default: begin
        end
      endcase
    end
  end

  assign used_mask = st_used_q;
  assign conflict  = st_conflict_q;
  assign malformed = st_malformed_q;
  assign changed   = st_changed_q;

endmodule : sudoku_unit_eliminator

// File: doc/sudoku_unit_eliminator.md
Name: sudoku_unit_eliminator

Overview:
- Bus initiator for one sudoku unit (row, column or box) of 9 cells, using the cells' shared word interface. Word address 0 holds a cell's value; address 1 holds its candidate mask.
- On start, reads all 9 cell values and ORs the solved digits into a used mask. It then writes ~used to every cell's candidate mask.
- Flags duplicate digits and malformed values.
- Sits between the board-level solver sequencer and a per-unit mux of 9 cells.

Parameters:
- SKIP_WRITE_ON_ERROR, 1, when 1 the write pass is skipped if a conflict or malformed value is found.
- CELL_W, 9, digit/mask width (bits 9:1). Fixed at 9; not intended to be overridden.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request one elimination pass; sampled only in IDLE
- busy  out  1  high from the cycle after start is accepted through the DONE cycle
- done  out  1  one-cycle pulse; status outputs are valid from this cycle
- cell_sel  out  4  selected cell index, 0..8
- cell_addr  out  1  0 = value word, 1 = candidate-mask word
- cell_we  out  1  write strobe to the selected cell
- cell_wdata  out  9  write data, bits 9:1
- cell_rdata  in  9  combinational read data from the selected cell at cell_addr, bits 9:1
- used_mask  out  9  OR of all solved values from the last pass
- conflict  out  1  last pass found the same digit solved in two or more cells
- malformed  out  1  last pass found a nonzero value that is not one-hot
- changed  out  1  last write pass cleared at least one candidate bit

Behaviour:
- States: IDLE, READ, WRITE, DONE. A 4-bit index counts 0..8 in READ and in WRITE.
- IDLE:
  - Bus outputs: sel=0, addr=0, we=0, wdata=0.
  - start=1 -> READ, index=0; clear the accumulators (used, conflict, malformed, changed).
- READ, one cell per cycle:
  - Drive sel=index, addr=0, we=0; sample cell_rdata in the same cycle.
  - rdata nonzero and not one-hot -> set malformed; do not OR it into used.
  - rdata one-hot and (rdata & used) != 0 -> set conflict.
  - used |= rdata when rdata is one-hot.
  - index==8 -> go to WRITE with index=0. If SKIP_WRITE_ON_ERROR=1 and an error flag is set, including one set by cell 8 in that same cycle, go to DONE instead.
- WRITE, one cell per cycle:
  - Drive sel=index, addr=1, we=1, wdata=~used (uses the final used value).
  - cell_rdata shows the pre-write mask that cycle. (rdata & used) != 0 -> set changed.
  - index==8 -> DONE.
- DONE:
  - done=1 and busy=1 for exactly one cycle, then -> IDLE.
  - Bus outputs are idle values, as in IDLE.
- Status outputs:
  - used_mask, conflict, malformed and changed are registered from the accumulators on entry to DONE.
  - They hold until the next DONE. They are not cleared by a new start.
- Latency, with start sampled high at cycle 0:
  - READ covers cycles 1–9; WRITE covers 10–18; done at cycle 19.
  - With the write pass skipped, done is at cycle 10.
- Boundary behaviour:
  - start while busy is ignored.
  - start held high continuously gives back-to-back passes with one IDLE cycle between done and the next READ.
  - All cells unsolved: used=0, wdata=9'h1FF, changed=0.
  - All cells solved: wdata=0. The cells ignore the mask contents and force their own candidate masks to 0.
- Reset, including mid-pass: state=IDLE, index=0, all bus outputs 0, busy=0, done=0, all status outputs 0.
- There are no partial writes after reset. we must be low in the reset cycle and the cycle after.

Decomposition:
- sudoku_pkg holds:
  - CELL_W=9 and UNIT_CELLS=9
  - the cell address constants ADDR_VALUE=0 and ADDR_MASK=1
  - the state enum for IDLE/READ/WRITE/DONE
- One sub-module, sudoku_onehot_check: combinational, takes the 9-bit input and outputs is_zero and is_onehot. It is reusable by the board sequencer.

Test Plan:
- Cell values {0,1<<3,0,1<<7,0,0,1<<1,0,0}, all masks 1FF; pulse start.
  -> done at cycle 19; used_mask=0x8A; wdata=0x175 on every WRITE cycle; changed=1; conflict=0; malformed=0.
- Two cells both hold 1<<5, SKIP_WRITE_ON_ERROR=1.
  -> conflict=1; done at cycle 10; cell_we never asserted.
- Cell 4 value = 0x006 (two bits set).
  -> malformed=1; 0x006 excluded from used_mask; write pass skipped.
- Rerun the first scenario after its write pass has completed.
  -> changed=0; used_mask unchanged.
- Assert reset at cycle 12 (mid-WRITE).
  -> next cycle: we=0, busy=0, status outputs=0; a fresh start completes normally.
- start held high for 50 cycles.
  -> done pulses at cycles 19 and 39; start is ignored while busy; exactly 9 we pulses per pass.
